// File: rtl/tvout_gen_if.sv
// Video timing bundle between the tvout_gen generator and its consumers
// (DAC/sync mixer, pixel fetch). The generator drives the timing; the consumer drives the mode select.
interface tvout_gen_if #(
  parameter int HW = 9,
  parameter int VW = 9
);
  logic          interlace;
  logic [HW-1:0] cntHS;
  logic [VW-1:0] cntVS;
  logic          field;
  logic          vbl;
  logic          hsync;
  logic          de;
  logic          line_start;
  logic          frame_start;
  logic          out_sync;

  modport master (
    input  interlace,
    output cntHS, cntVS, field, vbl, hsync, de, line_start, frame_start, out_sync
  );

  modport slave (
    output interlace,
    input  cntHS, cntVS, field, vbl, hsync, de, line_start, frame_start, out_sync
  );
endinterface

// File: rtl/tvout_gen.sv
// Parametrised composite-video timing generator: pixel/line counters, composite sync with
// broad/equalising pulses, blanking, display enable, line/frame strobes, optional interlace.
module tvout_gen #(
   parameter int HW          = 9,
   parameter int VW          = 9,
   parameter int H_TOTAL     = 512,
   parameter int H_SYNC      = 37,
   parameter int EQ_W        = 16,
   parameter int V_TOTAL     = 312,
   parameter int BROAD_LINES = 2,
   parameter int VBL_END     = 5,
   parameter int VBL_START   = 309,
   parameter int H_ACT_START = 96,
   parameter int H_ACT_END   = 480
) (
   input  logic       pixel_clk,
   input  logic       rst_n,
   tvout_gen_if.master vid
);

   localparam int HALF = H_TOTAL / 2;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_SYNC_E = HW'(H_SYNC);
   localparam logic [HW-1:0] H_BRD_1  = HW'(HALF - EQ_W);
   localparam logic [HW-1:0] H_HALF   = HW'(HALF);
   localparam logic [HW-1:0] H_BRD_2  = HW'(H_TOTAL - EQ_W);
   localparam logic [HW-1:0] H_EQ_1   = HW'(EQ_W);
   localparam logic [HW-1:0] H_EQ_2   = HW'(HALF + EQ_W);
   localparam logic [HW-1:0] H_DE_0   = HW'(H_ACT_START);
   localparam logic [HW-1:0] H_DE_1   = HW'(H_ACT_END);

   localparam logic [VW-1:0] V_LAST_E = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST_O = VW'(V_TOTAL);
   localparam logic [VW-1:0] V_BROAD  = VW'(BROAD_LINES);
   localparam logic [VW-1:0] V_VBL_E  = VW'(VBL_END);
   localparam logic [VW-1:0] V_VBL_S  = VW'(VBL_START);

   logic [HW-1:0] h_q, h_n;
   logic [VW-1:0] v_q, v_n, v_last;
   logic          field_q, field_n;
   logic          intl_q, intl_n;

   logic vbl_q, vbl_n;
   logic hsync_q, hsync_n;
   logic de_q, de_n;
   logic ls_q, ls_n;
   logic fs_q, fs_n;
   logic sync_q, sync_n;

   // NOTE: every variable written here gets a default first, so no path can infer a latch.
   always_comb begin
      h_n     = h_q + HW'(1);
      v_n     = v_q;
      field_n = field_q;
      intl_n  = intl_q;
      // The odd field of an interlaced frame carries one extra line.
      v_last  = (intl_q & field_q) ? V_LAST_O : V_LAST_E;
      if (h_q >= H_LAST) begin
         h_n = '0;
         if (v_q >= v_last) begin
            v_n     = '0;
            intl_n  = vid.interlace;
            field_n = vid.interlace ? ~field_q : 1'b0;
         end else begin
            v_n = v_q + VW'(1);
         end
      end
   end

   // Derived outputs are decoded from the next counter values so that, once registered,
   // they line up with the counters they describe.
   always_comb begin
      vbl_n   = (v_n < V_VBL_E) || (v_n >= V_VBL_S);
      hsync_n = (h_n < H_SYNC_E);
      de_n    = !vbl_n && (h_n >= H_DE_0) && (h_n < H_DE_1);
      ls_n    = (h_n == '0);
      fs_n    = ls_n && (v_n == '0);
      if (v_n < V_BROAD) begin
         sync_n = !((h_n < H_BRD_1) || ((h_n >= H_HALF) && (h_n < H_BRD_2)));
      end else if (v_n == V_BROAD) begin
         sync_n = !((h_n < H_BRD_1) || ((h_n >= H_HALF) && (h_n < H_EQ_2)));
      end else if (vbl_n) begin
         sync_n = !((h_n < H_EQ_1) || ((h_n >= H_HALF) && (h_n < H_EQ_2)));
      end else begin
         sync_n = !(h_n < H_SYNC_E);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         field_q <= 1'b0;
         intl_q  <= 1'b0;
         vbl_q   <= 1'b1;
         hsync_q <= 1'b1;
         de_q    <= 1'b0;
         ls_q    <= 1'b0;
         fs_q    <= 1'b0;
         sync_q  <= 1'b0;
      end else begin
         h_q     <= h_n;
         v_q     <= v_n;
         field_q <= field_n;
         intl_q  <= intl_n;
         vbl_q   <= vbl_n;
         hsync_q <= hsync_n;
         de_q    <= de_n;
         ls_q    <= ls_n;
         fs_q    <= fs_n;
         sync_q  <= sync_n;
      end
   end

   assign vid.cntHS       = h_q;
   assign vid.cntVS       = v_q;
   assign vid.field       = field_q;
   assign vid.vbl         = vbl_q;
   assign vid.hsync       = hsync_q;
   assign vid.de          = de_q;
   assign vid.line_start  = ls_q;
   assign vid.frame_start = fs_q;
   assign vid.out_sync    = sync_q;

endmodule

// File: tb/tb_tvout_gen.sv
// Directed bench for tvout_gen: a default-parameter instance for the line-level sync pattern and a
// reduced-size instance (64 x 20 lines) for frame wrap, interlace and asynchronous reset.
module tb_tvout_gen;

   logic pixel_clk = 1'b0;
   logic rst_n     = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   tvout_gen_if #(.HW(9), .VW(9)) vid_d ();
   tvout_gen_if #(.HW(6), .VW(5)) vid_s ();

   tvout_gen u_def (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .vid       (vid_d)
   );

   // Small frame: H_TOTAL=64 (HALF=32), EQ_W=4, V_TOTAL=20, blanked lines 0..4 and 17..19.
   tvout_gen #(
      .HW(6), .VW(5), .H_TOTAL(64), .H_SYNC(5), .EQ_W(4), .V_TOTAL(20), .BROAD_LINES(2),
      .VBL_END(5), .VBL_START(17), .H_ACT_START(12), .H_ACT_END(56)
   ) u_small (
      .pixel_clk (pixel_clk),
      .rst_n     (rst_n),
      .vid       (vid_s)
   );

   // Clock edges since the last reset release; edge n places the counters at pixel n of the frame.
   int cyc;
   always @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic goto(input int n);
      int guard = 0;
      while (cyc < n && guard < 20000) begin
         @(posedge pixel_clk);
         #1;
         guard++;
      end
      if (cyc != n) begin
         n_checks++;
         n_errors++;
         $display("FAIL goto: reached edge %0d expected %0d", cyc, n);
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge pixel_clk);
      #3;
   endtask

   // Default instance: expected counters follow from n, the rest is hand-computed.
   task automatic vec_d(input int n, input bit s, input bit vb, input bit d, input bit hs);
      goto(n);
      check($sformatf("d%0d_h", n), 32'(vid_d.cntHS), n % 512);
      check($sformatf("d%0d_v", n), 32'(vid_d.cntVS), n / 512);
      check($sformatf("d%0d_sync", n), 32'(vid_d.out_sync), 32'(s));
      check($sformatf("d%0d_vbl", n), 32'(vid_d.vbl), 32'(vb));
      check($sformatf("d%0d_de", n), 32'(vid_d.de), 32'(d));
      check($sformatf("d%0d_hsync", n), 32'(vid_d.hsync), 32'(hs));
   endtask

   task automatic pos_s(input string tag, input int n, input int h, input int v);
      goto(n);
      check({tag, "_h"}, 32'(vid_s.cntHS), h);
      check({tag, "_v"}, 32'(vid_s.cntVS), v);
   endtask

   initial begin
      vid_d.interlace = 1'b0;
      vid_s.interlace = 1'b0;

      // Reset values on the default instance while reset is held.
      hold_reset();
      check("rst_h", 32'(vid_d.cntHS), 0);
      check("rst_v", 32'(vid_d.cntVS), 0);
      check("rst_field", 32'(vid_d.field), 0);
      check("rst_vbl", 32'(vid_d.vbl), 1);
      check("rst_hsync", 32'(vid_d.hsync), 1);
      check("rst_de", 32'(vid_d.de), 0);
      check("rst_ls", 32'(vid_d.line_start), 0);
      check("rst_fs", 32'(vid_d.frame_start), 0);
      check("rst_sync", 32'(vid_d.out_sync), 0);
      rst_n = 1'b1;

      // Line 0 broad pulses: low 0..239 and 256..495.
      vec_d(1,   0, 1, 0, 1);
      vec_d(239, 0, 1, 0, 0);
      vec_d(240, 1, 1, 0, 0);
      vec_d(256, 0, 1, 0, 0);
      vec_d(495, 0, 1, 0, 0);
      vec_d(496, 1, 1, 0, 0);
      goto(511);
      check("wrap511_ls", 32'(vid_d.line_start), 0);
      vec_d(512, 0, 1, 0, 1);
      check("wrap512_ls", 32'(vid_d.line_start), 1);
      check("wrap512_fs", 32'(vid_d.frame_start), 0);
      goto(513);
      check("wrap513_ls", 32'(vid_d.line_start), 0);
      // Line 2: broad then equalising (low 0..239, 256..271).
      vec_d(1263, 0, 1, 0, 0);
      vec_d(1264, 1, 1, 0, 0);
      vec_d(1280, 0, 1, 0, 0);
      vec_d(1295, 0, 1, 0, 0);
      vec_d(1296, 1, 1, 0, 0);
      // Line 3: equalising (low 0..15, 256..271).
      vec_d(1551, 0, 1, 0, 1);
      vec_d(1552, 1, 1, 0, 1);
      vec_d(1791, 1, 1, 0, 0);
      vec_d(1792, 0, 1, 0, 0);
      vec_d(1807, 0, 1, 0, 0);
      vec_d(1808, 1, 1, 0, 0);
      vec_d(2048, 0, 1, 0, 1);
      // Line 5: first active line, sync low 0..36, de on 96..479.
      vec_d(2596, 0, 0, 0, 1);
      vec_d(2597, 1, 0, 0, 0);
      vec_d(2655, 1, 0, 0, 0);
      vec_d(2656, 1, 0, 1, 0);
      vec_d(3039, 1, 0, 1, 0);
      vec_d(3040, 1, 0, 0, 0);

      // Small instance, progressive.
      hold_reset();
      rst_n = 1'b1;
      pos_s("p1", 1, 1, 0);
      goto(27);
      check("p_l0_h27_sync", 32'(vid_s.out_sync), 0);
      goto(28);
      check("p_l0_h28_sync", 32'(vid_s.out_sync), 1);
      goto(59);
      check("p_l0_h59_sync", 32'(vid_s.out_sync), 0);
      goto(60);
      check("p_l0_h60_sync", 32'(vid_s.out_sync), 1);
      goto(1035);
      check("p_l16_h11_de", 32'(vid_s.de), 0);
      goto(1036);
      check("p_l16_h12_de", 32'(vid_s.de), 1);
      check("p_l16_vbl", 32'(vid_s.vbl), 0);
      goto(1088);
      check("p_l17_vbl", 32'(vid_s.vbl), 1);
      pos_s("p1279", 1279, 63, 19);
      check("p1279_fs", 32'(vid_s.frame_start), 0);
      pos_s("p1280", 1280, 0, 0);
      check("p1280_fs", 32'(vid_s.frame_start), 1);
      check("p1280_ls", 32'(vid_s.line_start), 1);
      check("p1280_field", 32'(vid_s.field), 0);
      goto(1281);
      check("p1281_fs", 32'(vid_s.frame_start), 0);
      goto(2559);
      check("p2559_fs", 32'(vid_s.frame_start), 0);
      pos_s("p2560", 2560, 0, 0);
      check("p2560_fs", 32'(vid_s.frame_start), 1);
      check("p2560_field", 32'(vid_s.field), 0);

      // Interlace from reset: frame 0 even (20 lines), frame 1 odd (21 lines).
      vid_s.interlace = 1'b1;
      hold_reset();
      rst_n = 1'b1;
      pos_s("i1279", 1279, 63, 19);
      check("i1279_field", 32'(vid_s.field), 0);
      pos_s("i1280", 1280, 0, 0);
      check("i1280_field", 32'(vid_s.field), 1);
      check("i1280_fs", 32'(vid_s.frame_start), 1);
      goto(2000);
      vid_s.interlace = 1'b0;
      check("i2000_field", 32'(vid_s.field), 1);
      pos_s("i2559", 2559, 63, 19);
      pos_s("i2560", 2560, 0, 20);
      check("i2560_field", 32'(vid_s.field), 1);
      check("i2560_vbl", 32'(vid_s.vbl), 1);
      check("i2560_sync", 32'(vid_s.out_sync), 0);
      check("i2560_fs", 32'(vid_s.frame_start), 0);
      goto(2564);
      check("i2564_sync", 32'(vid_s.out_sync), 1);
      goto(2572);
      check("i2572_de", 32'(vid_s.de), 0);
      goto(2592);
      check("i2592_sync", 32'(vid_s.out_sync), 0);
      goto(2596);
      check("i2596_sync", 32'(vid_s.out_sync), 1);
      pos_s("i2623", 2623, 63, 20);
      pos_s("i2624", 2624, 0, 0);
      check("i2624_field", 32'(vid_s.field), 0);
      check("i2624_fs", 32'(vid_s.frame_start), 1);
      pos_s("i3903", 3903, 63, 19);
      pos_s("i3904", 3904, 0, 0);
      check("i3904_field", 32'(vid_s.field), 0);
      check("i3904_fs", 32'(vid_s.frame_start), 1);

      // Asynchronous reset mid-frame, between clock edges.
      hold_reset();
      rst_n = 1'b1;
      pos_s("a990", 990, 30, 15);
      check("a990_de", 32'(vid_s.de), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("a_h", 32'(vid_s.cntHS), 0);
      check("a_v", 32'(vid_s.cntVS), 0);
      check("a_vbl", 32'(vid_s.vbl), 1);
      check("a_de", 32'(vid_s.de), 0);
      check("a_hsync", 32'(vid_s.hsync), 1);
      check("a_sync", 32'(vid_s.out_sync), 0);
      #2;
      rst_n = 1'b1;
      pos_s("a1", 1, 1, 0);
      pos_s("a64", 64, 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
